// File: rtl/data_mem_initiator_pkg.sv
// Shared definitions for the data-memory initiator:
// access size codes, FSM states and the default data-space limit.
package data_mem_initiator_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WSET,
        S_WPUL,
        S_RESP
    } state_e;

    localparam logic [31:0] DATA_LIMIT_DEF = 32'h0000_0FFC;

    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/data_mem_initiator_if.sv
// Request/response handshake plus memory-side bus of the
// data-memory initiator; master = pipeline/memory side, slave = initiator.
interface data_mem_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] data_out;

    modport master (
        output req_valid, req_we, req_size, req_signed,
        output req_addr, req_wdata, data_out,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  data_addr, data_in, mem_read, mem_write
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed,
        input  req_addr, req_wdata, data_out,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output data_addr, data_in, mem_read, mem_write
    );
endinterface

// File: rtl/data_mem_initiator_lane_align.sv
// mem_lane_align: combinational load extract/extend and
// store lane merge into the word read back from memory.
module mem_lane_align
    import data_mem_initiator_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  size_e       size,
    input  logic        sgn,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);
    logic [7:0]  b;
    logic [15:0] h;

    // half lane uses only addr[1]: misaligned halves fold onto it
    assign b = word[{lane, 3'b000} +: 8];
    assign h = word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = word;
        st_word = wdata;
        unique case (1'b1)
            size == SZ_BYTE: begin
                ld_data = {{24{sgn & b[7]}}, b};
                st_word = word;
                st_word[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            size == SZ_HALF: begin
                ld_data = {{16{sgn & h[15]}}, h};
                st_word = word;
                st_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: begin
                ld_data = word;
                st_word = wdata;
            end
        endcase
    end
endmodule

// File: rtl/data_mem_initiator.sv
// Data-memory initiator: load/store sequencing with RMW sub-word stores.
// Define MEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module data_mem_initiator
    import data_mem_initiator_pkg::*;
#(
    parameter int          RD_WAIT    = 1,
    parameter int          WR_HOLD    = 2,
    parameter logic [31:0] DATA_LIMIT = DATA_LIMIT_DEF
) (
    input logic clk,
    input logic rst,
    data_mem_initiator_if.slave bus
);
    state_e      state;
    state_e      nxt;
    logic [15:0] cnt;
    logic        live;
    logic        we_r;
    logic        sgn_r;
    logic        err_r;
    size_e       size_r;
    logic [1:0]  lane_r;
    logic [31:0] wdata_r;
    logic [31:0] rdata_r;
    logic [31:0] addr_r;
    logic [31:0] din_r;
    logic        accept;
    logic        fault;
    logic        misalign;
    logic        last_rd;
    logic        last_wr;
    logic [31:0] ld_data;
    logic [31:0] st_word;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = (bus.req_size == SZ_HALF && bus.req_addr[0]) ||
                      (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign fault = (bus.req_size == SZ_RSVD) ||
                   (word_addr(bus.req_addr) > DATA_LIMIT) ||
                   misalign;

    assign accept  = bus.req_valid && bus.req_ready;
    assign last_rd = cnt == 16'(RD_WAIT - 1);
    assign last_wr = cnt == 16'(WR_HOLD - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (fault)                        nxt = S_RESP;
                    else if (!bus.req_we)             nxt = S_RD;
                    else if (bus.req_size == SZ_WORD) nxt = S_WSET;
                    else                              nxt = S_RD;
                end
            end
            S_RD:    if (last_rd) nxt = we_r ? S_WSET : S_RESP;
            S_WSET:  nxt = S_WPUL;
            S_WPUL:  if (last_wr) nxt = S_RESP;
            S_RESP:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    mem_lane_align u_align (
        .word    (bus.data_out),
        .lane    (lane_r),
        .size    (size_r),
        .sgn     (sgn_r),
        .wdata   (wdata_r),
        .ld_data (ld_data),
        .st_word (st_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live    <= 1'b0;
            cnt     <= '0;
            we_r    <= 1'b0;
            sgn_r   <= 1'b0;
            err_r   <= 1'b0;
            size_r  <= SZ_BYTE;
            lane_r  <= 2'b00;
            wdata_r <= '0;
            rdata_r <= '0;
            addr_r  <= '0;
            din_r   <= '0;
        end else begin
            live <= 1'b1;
            cnt  <= (nxt != state) ? '0 : cnt + 16'd1;
            if (accept) begin
                we_r    <= bus.req_we;
                sgn_r   <= bus.req_signed;
                err_r   <= fault;
                size_r  <= size_e'(bus.req_size);
                lane_r  <= bus.req_addr[1:0];
                wdata_r <= bus.req_wdata;
                rdata_r <= '0;
                if (!fault)
                    addr_r <= word_addr(bus.req_addr);
                if (!fault && bus.req_we && bus.req_size == SZ_WORD)
                    din_r <= bus.req_wdata;
            end
            // final read edge: either the load result or the merged RMW word
            if (state == S_RD && last_rd) begin
                if (we_r) din_r   <= st_word;
                else      rdata_r <= ld_data;
            end
        end
    end

    assign bus.req_ready = live && (state == S_IDLE);
    assign bus.mem_read  = state == S_RD;
    assign bus.mem_write = state == S_WPUL;
    assign bus.rsp_valid = state == S_RESP;
    assign bus.rsp_err   = bus.rsp_valid && err_r;
    assign bus.rsp_rdata = bus.rsp_valid ? rdata_r : '0;
    assign bus.data_addr = addr_r;
    assign bus.data_in   = din_r;
endmodule

// File: tb/tb_data_mem_initiator.sv
// Randomized self-checking bench for data_mem_initiator with a
// word-array memory and an arithmetic reference model.
module tb_data_mem_initiator;
    localparam int          RD_WAIT = 1;
    localparam int          WR_HOLD = 2;
    localparam logic [31:0] LIMIT   = 32'h0000_0FFC;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk;
    logic rst;
    data_mem_initiator_if bus();

    data_mem_initiator #(
        .RD_WAIT    (RD_WAIT),
        .WR_HOLD    (WR_HOLD),
        .DATA_LIMIT (LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];
    int wr_rises = 0;
    int overlap = 0;
    int low_run = 0;
    int gap_min = 1000;
    bit wrote = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.data_out = mem[bus.data_addr[11:2]];

    always @(posedge bus.mem_write) begin
        mem[bus.data_addr[11:2]] = bus.data_in;
        wr_rises++;
        if (wrote && low_run < gap_min) gap_min = low_run;
        wrote = 1'b1;
    end

    always @(posedge clk) begin
        if (bus.mem_write) low_run = 0;
        else low_run++;
        if (bus.mem_read && bus.mem_write) overlap++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic bit exp_fault(logic [1:0] sz, logic [31:0] a);
        bit mis;
        mis = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        return sz == 2'd3 || (a & ~32'h3) > LIMIT || (TRAP && mis);
    endfunction

    function automatic logic [31:0] exp_load(logic [1:0] sz, bit sg, logic [31:0] a);
        logic [31:0] w;
        logic [31:0] v;
        w = ref_mem[(a >> 2) & 1023];
        v = w;
        if (sz == 2'd0) begin
            v = (w >> (8 * (a % 4))) & 32'hFF;
            if (sg && v > 32'h7F) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (w >> (16 * ((a >> 1) % 2))) & 32'hFFFF;
            if (sg && v > 32'h7FFF) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic ref_store(logic [1:0] sz, logic [31:0] a, logic [31:0] wd);
        int idx;
        int sh;
        logic [31:0] m;
        idx = int'((a >> 2) & 1023);
        if (sz == 2'd0) begin
            sh = 8 * int'(a % 4);
            m = 32'hFF << sh;
            ref_mem[idx] = (ref_mem[idx] & ~m) | ((wd & 32'hFF) << sh);
        end else if (sz == 2'd1) begin
            sh = 16 * int'((a >> 1) % 2);
            m = 32'hFFFF << sh;
            ref_mem[idx] = (ref_mem[idx] & ~m) | ((wd & 32'hFFFF) << sh);
        end else begin
            ref_mem[idx] = wd;
        end
    endtask

    function automatic int exp_lat(bit we, logic [1:0] sz, bit f);
        if (f) return 1;
        if (!we) return RD_WAIT + 1;
        if (sz == 2'd2) return WR_HOLD + 2;
        return RD_WAIT + WR_HOLD + 2;
    endfunction

    task automatic preload(int idx, logic [31:0] v);
        mem[idx] = v;
        ref_mem[idx] = v;
    endtask

    task automatic do_req(input bit we, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output bit er,
                          output int lat, output int rises, output int rdc);
        int g;
        int w0;
        g = 0;
        @(negedge clk);
        while (!bus.req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        w0 = wr_rises;
        rdc = 0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 30) begin
            if (bus.mem_read) rdc++;
            @(posedge clk);
            #1;
            lat++;
        end
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        rises = wr_rises - w0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_size = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_read, bus.mem_write} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b want 00000",
                     {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_read, bus.mem_write});
        end
        checks++;
        if ({bus.rsp_rdata, bus.data_addr, bus.data_in} !== 96'b0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h want 0",
                     bus.rsp_rdata, bus.data_addr, bus.data_in);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", bus.req_ready);
        end
    endtask

    task automatic test_word;
        logic [31:0] rd;
        bit er;
        int lat, rises, rdc;
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, er, lat, rises, rdc);
        ref_store(2'd2, 32'h10, 32'hDEAD_BEEF);
        checks++;
        if (lat !== 4 || er !== 1'b0 || rises !== 1 || rdc !== 0) begin
            errors++;
            $display("FAIL word_store got lat=%0d err=%0d rises=%0d rd=%0d want 4 0 1 0",
                     lat, er, rises, rdc);
        end
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, rises, rdc);
        checks++;
        if (rd !== 32'hDEAD_BEEF || lat !== 2 || er !== 1'b0 || rdc !== RD_WAIT) begin
            errors++;
            $display("FAIL word_load got %h lat=%0d err=%0d want deadbeef lat=2 err=0",
                     rd, lat, er);
        end
    endtask

    task automatic test_byte_store;
        logic [31:0] rd;
        bit er;
        int lat, rises, rdc;
        preload(8, 32'h1122_3344);
        do_req(1'b1, 2'd0, 1'b0, 32'h22, 32'h0000_00AA, rd, er, lat, rises, rdc);
        ref_store(2'd0, 32'h22, 32'hAA);
        checks++;
        if (mem[8] !== 32'h11AA_3344 || rises !== 1 || lat !== 5) begin
            errors++;
            $display("FAIL byte_store got %h rises=%0d lat=%0d want 11aa3344 1 5",
                     mem[8], rises, lat);
        end
    endtask

    task automatic test_signed_load;
        logic [31:0] rd;
        bit er;
        int lat, rises, rdc;
        preload(8, 32'h8022_3344);
        do_req(1'b0, 2'd0, 1'b1, 32'h23, 32'h0, rd, er, lat, rises, rdc);
        checks++;
        if (rd !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL load_byte_signed got %h want ffffff80", rd);
        end
        do_req(1'b0, 2'd0, 1'b0, 32'h23, 32'h0, rd, er, lat, rises, rdc);
        checks++;
        if (rd !== 32'h0000_0080) begin
            errors++;
            $display("FAIL load_byte_unsigned got %h want 00000080", rd);
        end
    endtask

    task automatic test_range;
        logic [31:0] rd;
        bit er;
        int lat, rises, rdc;
        do_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, rd, er, lat, rises, rdc);
        checks++;
        if (er !== 1'b1 || lat !== 1 || rdc !== 0 || rises !== 0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL range_fault got err=%0d lat=%0d rd=%0d wr=%0d data=%h want 1 1 0 0 0",
                     er, lat, rdc, rises, rd);
        end
        do_req(1'b1, 2'd3, 1'b0, 32'h40, 32'h1234, rd, er, lat, rises, rdc);
        checks++;
        if (er !== 1'b1 || lat !== 1 || rises !== 0) begin
            errors++;
            $display("FAIL size_fault got err=%0d lat=%0d wr=%0d want 1 1 0", er, lat, rises);
        end
    endtask

    task automatic test_misalign;
        logic [31:0] rd;
        bit er;
        int lat, rises, rdc;
        logic [31:0] erd;
        bit eer;
        preload(12, 32'hCAFE_1234);
        eer = TRAP;
        erd = TRAP ? 32'h0 : 32'h0000_1234;
        do_req(1'b0, 2'd1, 1'b0, 32'h31, 32'h0, rd, er, lat, rises, rdc);
        checks++;
        if (er !== eer || rd !== erd) begin
            errors++;
            $display("FAIL half_misalign got err=%0d %h want err=%0d %h", er, rd, eer, erd);
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, a, wd, erd;
        logic [1:0] sz;
        bit we, sg, er, ef;
        int lat, rises, rdc, el, bad;
        for (int i = 0; i < 80; i++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a  = (i % 2 == 0) ? 32'($urandom_range(0, 32'h3F))
                              : 32'($urandom_range(0, 32'h10FF));
            wd = $urandom;
            ef = exp_fault(sz, a);
            el = exp_lat(we, sz, ef);
            erd = (!we && !ef) ? exp_load(sz, sg, a) : 32'h0;
            do_req(we, sz, sg, a, wd, rd, er, lat, rises, rdc);
            if (we && !ef) ref_store(sz, a, wd);
            checks++;
            if (rd !== erd || er !== ef || lat !== el) begin
                errors++;
                $display("FAIL rand_rsp[%0d] we=%0d sz=%0d a=%h got %h/%0d/%0d want %h/%0d/%0d",
                         i, we, sz, a, rd, er, lat, erd, ef, el);
            end
            checks++;
            if (rises !== ((we && !ef) ? 1 : 0) ||
                rdc !== ((!ef && (!we || sz != 2'd2)) ? RD_WAIT : 0)) begin
                errors++;
                $display("FAIL rand_strobe[%0d] got wr=%0d rd=%0d", i, rises, rdc);
            end
        end
        bad = 0;
        for (int k = 0; k < 1024; k++)
            if (mem[k] !== ref_mem[k]) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL mem_image got %0d differing words want 0", bad);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        bit er;
        int lat, rises, rdc;
        gap_min = 1000;
        wrote = 1'b0;
        do_req(1'b1, 2'd2, 1'b0, 32'h50, 32'h0102_0304, rd, er, lat, rises, rdc);
        do_req(1'b1, 2'd2, 1'b0, 32'h54, 32'h0506_0708, rd, er, lat, rises, rdc);
        do_req(1'b1, 2'd0, 1'b0, 32'h51, 32'h0000_0099, rd, er, lat, rises, rdc);
        ref_store(2'd2, 32'h50, 32'h0102_0304);
        ref_store(2'd2, 32'h54, 32'h0506_0708);
        ref_store(2'd0, 32'h51, 32'h99);
        checks++;
        if (gap_min < 2 || gap_min >= 1000) begin
            errors++;
            $display("FAIL b2b_gap got %0d want >=2", gap_min);
        end
        checks++;
        if (mem[20] !== ref_mem[20] || mem[21] !== ref_mem[21]) begin
            errors++;
            $display("FAIL b2b_data got %h %h want %h %h", mem[20], mem[21], ref_mem[20], ref_mem[21]);
        end
        checks++;
        if (overlap !== 0) begin
            errors++;
            $display("FAIL rd_wr_overlap got %0d want 0", overlap);
        end
    endtask

    task automatic test_reset_mid;
        int g;
        @(negedge clk);
        g = 0;
        while (!bus.req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_size = 2'd2;
        bus.req_addr = 32'h60;
        bus.req_wdata = 32'h5A5A_A5A5;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        g = 0;
        while (!bus.mem_write && g < 20) begin
            @(posedge clk);
            #1;
            g++;
        end
        ref_store(2'd2, 32'h60, 32'h5A5A_A5A5);
        checks++;
        if (bus.mem_write !== 1'b1) begin
            errors++;
            $display("FAIL mid_reach_wpul got %b want 1", bus.mem_write);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.mem_read, bus.mem_write} !== 4'b0 ||
            {bus.rsp_rdata, bus.data_addr, bus.data_in} !== 96'b0) begin
            errors++;
            $display("FAIL mid_reset_out got ctl=%b addr=%h din=%h want 0",
                     {bus.req_ready, bus.rsp_valid, bus.mem_read, bus.mem_write},
                     bus.data_addr, bus.data_in);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || mem[24] !== 32'h5A5A_A5A5) begin
            errors++;
            $display("FAIL mid_reset_release got ready=%b mem=%h want 1 5a5aa5a5",
                     bus.req_ready, mem[24]);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) preload(i, $urandom);
        test_reset();
        test_word();
        test_byte_store();
        test_signed_load();
        test_range();
        test_misalign();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
